// File: rtl/imm_decode_stage.sv
// -----------------------------------------------------------------------------
// imm_decode_stage
//
// Purpose:
//   Pipeline stage that extracts the immediate from a 32-bit RISC-V style
//   instruction word, extends it to XLEN bits and presents it together with
//   the original instruction, the format that was applied and an illegal flag.
//   The output side is either a two-entry skid buffer (SKID=1, fully
//   registered in_ready) or a single output register (SKID=0).
//
// Parameters:
//   XLEN     - width of out_imm, 32 or 64
//   AUTO_SEL - 1: format is derived from the opcode and in_sel is ignored
//   SKID     - 1: main register + skid entry, 0: main register only
//
// Ports:
//   clk           - clock, all state on the rising edge
//   rst           - asynchronous active-high reset
//   flush         - drop every held entry on the next edge, accept nothing
//   in_valid      - upstream offers in_inst / in_sel
//   in_ready      - stage can take an instruction this cycle
//   in_inst       - instruction word
//   in_sel        - format select (000 I, 001 S, 010 B, 011 U, 100 J,
//                   101 CSR-zimm, 110/111 illegal)
//   out_valid     - a decoded result is held at the outputs
//   out_ready     - downstream takes the held result this cycle
//   out_imm       - decoded immediate
//   out_inst      - instruction paired with out_imm
//   out_fmt       - format actually applied
//   out_illegal   - the format is not supported (out_imm is then 0)
//   illegal_count - saturating count of illegal results handed downstream
// -----------------------------------------------------------------------------
module imm_decode_stage #(
    parameter int XLEN     = 32,
    parameter int AUTO_SEL = 0,
    parameter int SKID     = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [2:0]      in_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [31:0]     out_inst,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [15:0]     illegal_count
);

    localparam logic [2:0] FMT_I   = 3'b000;
    localparam logic [2:0] FMT_S   = 3'b001;
    localparam logic [2:0] FMT_B   = 3'b010;
    localparam logic [2:0] FMT_U   = 3'b011;
    localparam logic [2:0] FMT_J   = 3'b100;
    localparam logic [2:0] FMT_Z   = 3'b101;
    localparam logic [2:0] FMT_BAD = 3'b111;

    // Handshake: a word moves across a port on a rising edge where that
    // port's valid and ready are both high. valid never waits for ready, and
    // the output payload is frozen while out_valid && !out_ready. flush and
    // rst override the handshake: nothing is taken in while either is high,
    // because the upstream side is being discarded at the same time.

    // ---------------------------------------------------------------- decode
    logic [2:0]      auto_fmt;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;
    logic            sgn;

    always_comb begin
        auto_fmt = FMT_BAD;
        case (in_inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: auto_fmt = FMT_I;
            7'b0100011:                         auto_fmt = FMT_S;
            7'b1100011:                         auto_fmt = FMT_B;
            7'b0110111, 7'b0010111:             auto_fmt = FMT_U;
            7'b1101111:                         auto_fmt = FMT_J;
            // SYSTEM: funct3[2] selects the immediate (zimm) CSR variants
            7'b1110011:                         auto_fmt = in_inst[14] ? FMT_Z : FMT_I;
            default:                            auto_fmt = FMT_BAD;
        endcase
    end

    assign dec_fmt     = (AUTO_SEL != 0) ? auto_fmt : in_sel;
    assign dec_illegal = dec_fmt[2] & dec_fmt[1];
    assign sgn         = in_inst[31];

    // The sign bit is replicated above the highest non-sign field bit so
    // that every replication count stays positive for XLEN=32.
    always_comb begin
        dec_imm = '0;
        case (dec_fmt)
            FMT_I: dec_imm = {{(XLEN-11){sgn}}, in_inst[30:20]};
            FMT_S: dec_imm = {{(XLEN-11){sgn}}, in_inst[30:25], in_inst[11:7]};
            FMT_B: dec_imm = {{(XLEN-12){sgn}}, in_inst[7], in_inst[30:25],
                              in_inst[11:8], 1'b0};
            FMT_U: dec_imm = {{(XLEN-31){sgn}}, in_inst[30:12], 12'b0};
            FMT_J: dec_imm = {{(XLEN-20){sgn}}, in_inst[19:12], in_inst[20],
                              in_inst[30:21], 1'b0};
            FMT_Z: dec_imm = {{(XLEN-5){1'b0}}, in_inst[19:15]};
            default: dec_imm = '0;
        endcase
    end

    // ------------------------------------------------------------- handshake
    logic            skid_full;
    logic [XLEN-1:0] skid_imm;
    logic [31:0]     skid_inst;
    logic [2:0]      skid_fmt;
    logic            skid_illegal;
    logic            accept;
    logic            out_fire;

    // With SKID=1 in_ready comes straight from a flop; with SKID=0 it looks
    // through to out_ready so the single register can refill every cycle.
    assign in_ready = (SKID != 0) ? !skid_full : (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_inst     <= '0;
            out_fmt      <= '0;
            out_illegal  <= 1'b0;
            skid_full    <= 1'b0;
            skid_imm     <= '0;
            skid_inst    <= '0;
            skid_fmt     <= '0;
            skid_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // Output register is free (or being emptied): the skid entry is
            // older than anything arriving now, so it goes first. in_ready is
            // low whenever the skid entry is full, so the two never collide.
            if (skid_full) begin
                out_valid   <= 1'b1;
                out_imm     <= skid_imm;
                out_inst    <= skid_inst;
                out_fmt     <= skid_fmt;
                out_illegal <= skid_illegal;
                skid_full   <= 1'b0;
            end else if (accept) begin
                out_valid   <= 1'b1;
                out_imm     <= dec_imm;
                out_inst    <= in_inst;
                out_fmt     <= dec_fmt;
                out_illegal <= dec_illegal;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            // Output stalled: only reachable with SKID=1, because with SKID=0
            // in_ready is low while the register is full and not draining.
            skid_full    <= 1'b1;
            skid_imm     <= dec_imm;
            skid_inst    <= in_inst;
            skid_fmt     <= dec_fmt;
            skid_illegal <= dec_illegal;
        end
    end

    // Counts only results that really leave the stage; a flush in the same
    // cycle cancels the transfer and therefore the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_count <= '0;
        end else if (!flush && out_fire && out_illegal && (illegal_count != 16'hFFFF)) begin
            illegal_count <= illegal_count + 16'd1;
        end
    end

endmodule
